msg_pack: RTL and testbench
===========================

Name: msg_pack

Overview:
- Upstream neighbour of the message-extract stage. Accepts individual messages on an AXI-Stream slave and packs them into one packet per flush.
- Packet format: 2-byte big-endian msg_count, then for each message a 2-byte big-endian length followed by its payload bytes. Everything is packed contiguously, byte 0 of the packet is in tdata[63:56], and output beats are 8 bytes.
- The whole packet is buffered internally, because msg_count must lead the packet.

Parameters:
- TDATA_WIDTH, 64, stream width in bits; only 64 is supported.
- MIN_MSGLEN, 8, minimum legal message length in bytes.
- MAX_MSGLEN, 32, maximum legal message length in bytes.
- MAX_PACKETLEN, 1500, byte buffer depth, including the header.
- MAX_MSGS, 16, message count that forces packet close.
- IDLE_TIMEOUT, 256, idle cycles before auto-close; 0 disables the timeout.

Ports:
- clk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- axis_in_tvalid  in  1  message beat valid
- axis_in_tready  out  1  beat accept
- axis_in_tdata  in  64  message bytes; byte k is in bits [63-8k:56-8k]
- axis_in_tkeep  in  8  on the tlast beat: count of valid bytes, 0 = 8; ignored on other beats (all 8 valid)
- axis_in_tlast  in  1  end of message
- axis_out_tvalid  out  1  packet beat valid
- axis_out_tready  in  1  downstream accept
- axis_out_tdata  out  64  packet bytes, same byte order as input
- axis_out_tkeep  out  8  byte mask; bit 7 = byte 0; all ones except on the final beat
- axis_out_tlast  out  1  final beat of packet
- flush_req  in  1  pulse: close the current packet at the next message boundary
- err_len  out  1  one-cycle pulse: message dropped because its length was illegal
- pkt_done  out  1  one-cycle pulse: final packet beat accepted

Behaviour:
- Reset, asynchronous and active-low:
  - state ACCUM; wr_ptr=2; msg_count=0; flags and idle counter cleared.
  - Outputs: tvalid=0, tlast=0, tkeep=0, tdata=0, err_len=0, pkt_done=0; axis_in_tready=0 while reset is asserted.
  - Assertion mid-packet discards the buffer; no partial output follows.
- States:
  - ACCUM: tready=1.
  - CLOSE: tready=0, one cycle; writes msg_count into bytes 0-1.
  - SEND: tready=0; streams bytes 0..wr_ptr-1.
- Message write path:
  - At the first beat of a message: len_ptr=wr_ptr; payload is written from len_ptr+2; msg_len counts bytes.
  - Payload bytes beyond MAX_MSGLEN are counted but not written, so the buffer is never overrun.
- On an accepted tlast beat:
  - If MIN_MSGLEN<=msg_len<=MAX_MSGLEN: write msg_len big-endian into bytes len_ptr and len_ptr+1; wr_ptr=len_ptr+2+msg_len; msg_count+1.
  - Otherwise: wr_ptr=len_ptr and err_len pulses the following cycle.
- Close triggers, evaluated only between messages:
  - (a) An accepted message brings msg_count to MAX_MSGS.
  - (b) wr_ptr+2+MAX_MSGLEN > MAX_PACKETLEN after an accepted message.
  - (c) Latched flush_req and msg_count>0.
  - (d) Idle counter reaches IDLE_TIMEOUT and msg_count>0.
  - On any trigger: ACCUM->CLOSE on the next cycle, with tready deasserted in that cycle.
- flush_req handling:
  - Latched while in ACCUM, including mid-message.
  - Cleared when the packet is closed, or if it is evaluated with msg_count==0.
  - Ignored in CLOSE and SEND.
- Idle counter:
  - Increments each ACCUM cycle with no accepted beat, while between messages and msg_count>0.
  - Resets on any accepted beat. Never runs mid-message.
- SEND timing and beats:
  - First tvalid appears the cycle after CLOSE.
  - Beat k carries bytes 8k..8k+7, and there are ceil(wr_ptr/8) beats.
  - tdata/tkeep/tlast are held stable while tvalid && !tready.
  - Final beat: tlast=1; tkeep has the top (wr_ptr mod 8) bits set (0 -> 0xFF); unused bytes are zero.
- End of packet:
  - When the final beat is accepted, pkt_done pulses in the same cycle.
  - Next cycle: ACCUM, wr_ptr=2, msg_count=0, idle counter=0, tready=1.
- Simultaneous events: a tlast beat that triggers (a) or (b) in the same cycle as flush_req produces exactly one close; the flush is consumed.
- Zero-message packets are never emitted.

Test Plan:
1. Two messages, 8 bytes (0x01..0x08) and 12 bytes (0x11..0x1C; tkeep=4 on last beat), then a flush_req pulse -> 26-byte packet 00 02 00 08 01..08 00 0C 11..1C; 4 beats, last beat tkeep=0xC0, tlast=1, pkt_done pulses once.
2. Sixteen 8-byte messages with no flush -> close after the 16th tlast; 162-byte packet, header 00 10, 21 beats, last tkeep=0xC0; tready low until final beat accepted.
3. Messages of 4 bytes and 40 bytes, then an 8-byte message and a flush -> err_len pulses twice; packet header 00 01, length 12 bytes.
4. One 8-byte message then idle with IDLE_TIMEOUT=256 -> CLOSE after 256 idle cycles; 12-byte packet 00 01 00 08 ..., 2 beats, last tkeep=0xF0.
5. Hold axis_out_tready=0 for 5 cycles during SEND, and pulse flush_req -> beat data stable, no duplicated or lost beat, flush ignored, next packet unaffected.
6. Assert areset_n low mid-SEND -> tvalid=0 immediately; after release, tready=1, and a fresh 8-byte message plus flush yields a correct 12-byte packet.

Source files
------------

// File: rtl/msg_pack.sv
// rtl/msg_pack.sv - packs AXI-Stream messages into counted, length-prefixed packets
module msg_pack #(
    parameter int TDATA_WIDTH   = 64,   // only 64 supported
    parameter int MIN_MSGLEN    = 8,
    parameter int MAX_MSGLEN    = 32,
    parameter int MAX_PACKETLEN = 1500,
    parameter int MAX_MSGS      = 16,
    parameter int IDLE_TIMEOUT  = 256
) (
    input  logic                     clk,
    input  logic                     areset_n,
    input  logic                     axis_in_tvalid,
    output logic                     axis_in_tready,
    input  logic [TDATA_WIDTH-1:0]   axis_in_tdata,
    input  logic [7:0]               axis_in_tkeep,
    input  logic                     axis_in_tlast,
    output logic                     axis_out_tvalid,
    input  logic                     axis_out_tready,
    output logic [TDATA_WIDTH-1:0]   axis_out_tdata,
    output logic [7:0]               axis_out_tkeep,
    output logic                     axis_out_tlast,
    input  logic                     flush_req,
    output logic                     err_len,
    output logic                     pkt_done
);
    localparam int PW = $clog2(MAX_PACKETLEN + 1);

    typedef enum logic [1:0] {ACCUM, CLOSE, SEND} state_t;
    state_t state, state_nx;

    logic [7:0]    mem [MAX_PACKETLEN];
    logic [PW-1:0] wr_ptr, len_ptr, cur_ptr, end_ptr, rd_base;
    logic [7:0]    rd_beat;
    logic [15:0]   msg_len, msg_count, idle_cnt, cur_len, new_len;
    logic [3:0]    nbytes;
    logic          in_msg, flush_flag, err_q;
    logic          close_now, close_full, acc, len_ok, msg_ok, last_beat;
    logic [7:0]    lane_we;
    logic [PW-1:0] lane_addr [8];
    logic [PW-1:0] rd_addr [8];

    // Message-boundary close decisions, handshake and length bookkeeping
    always_comb begin
        close_now = (state == ACCUM) && !in_msg && (msg_count != 16'd0) &&
                    (flush_flag || (IDLE_TIMEOUT != 0 && idle_cnt >= 16'(IDLE_TIMEOUT)));
        axis_in_tready = areset_n && (state == ACCUM) && !close_now;
        acc     = axis_in_tvalid && axis_in_tready;
        cur_ptr = in_msg ? len_ptr : wr_ptr;
        cur_len = in_msg ? msg_len : 16'd0;
        nbytes  = (!axis_in_tlast || axis_in_tkeep == 8'd0 || axis_in_tkeep >= 8'd8) ?
                  4'd8 : axis_in_tkeep[3:0];
        // saturate so absurdly long messages cannot wrap back into the legal range
        new_len = (cur_len >= 16'hFFF0) ? cur_len : cur_len + 16'(nbytes);
        len_ok  = (new_len >= 16'(MIN_MSGLEN)) && (new_len <= 16'(MAX_MSGLEN));
        msg_ok  = acc && axis_in_tlast && len_ok;
        end_ptr = cur_ptr + PW'(2) + PW'(new_len);
        close_full = msg_ok && ((msg_count + 16'd1 >= 16'(MAX_MSGS)) ||
                                (int'(end_ptr) + 2 + MAX_MSGLEN > MAX_PACKETLEN));
        rd_base   = PW'(rd_beat) << 3;
        last_beat = (rd_base + PW'(8) >= wr_ptr);
    end

    // Per-lane payload write enables; bytes past MAX_MSGLEN are counted only
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lane_addr[i] = cur_ptr + PW'(2) + PW'(cur_len) + PW'(i);
            lane_we[i]   = acc && (i < int'(nbytes)) && (int'(cur_len) + i < MAX_MSGLEN) &&
                           (int'(lane_addr[i]) < MAX_PACKETLEN);
        end
    end

    // Packet buffer writes: payload lanes, length field, and header at close
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (lane_we[i]) mem[lane_addr[i]] <= axis_in_tdata[63-8*i -: 8];
        end
        if (msg_ok) begin
            mem[cur_ptr]         <= new_len[15:8];
            mem[cur_ptr + PW'(1)] <= new_len[7:0];
        end
        if (state == CLOSE) begin
            mem[0] <= msg_count[15:8];
            mem[1] <= msg_count[7:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) state <= ACCUM;
        else           state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ACCUM:   if (close_now || close_full) state_nx = CLOSE;
            CLOSE:   state_nx = SEND;
            SEND:    if (axis_out_tready && last_beat) state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    // Datapath registers: pointers, counters, flush latch, idle timer, read beat
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr     <= PW'(2);
            len_ptr    <= '0;
            msg_len    <= '0;
            msg_count  <= '0;
            idle_cnt   <= '0;
            in_msg     <= 1'b0;
            flush_flag <= 1'b0;
            err_q      <= 1'b0;
            rd_beat    <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ACCUM: begin
                    if (acc) begin
                        idle_cnt <= '0;
                        if (axis_in_tlast) begin
                            in_msg  <= 1'b0;
                            msg_len <= '0;
                            if (len_ok) begin
                                wr_ptr    <= end_ptr;
                                msg_count <= msg_count + 16'd1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            in_msg  <= 1'b1;
                            len_ptr <= cur_ptr;
                            msg_len <= new_len;
                        end
                    end else if (!in_msg && msg_count != 16'd0) begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                    if (close_now || close_full)
                        flush_flag <= 1'b0;
                    else if (flush_req)
                        flush_flag <= 1'b1;
                    else if (!in_msg && msg_count == 16'd0)
                        flush_flag <= 1'b0;
                end
                CLOSE: begin
                    rd_beat  <= '0;
                    idle_cnt <= '0;
                end
                SEND: begin
                    if (axis_out_tready) begin
                        if (last_beat) begin
                            wr_ptr     <= PW'(2);
                            msg_count  <= '0;
                            idle_cnt   <= '0;
                            rd_beat    <= '0;
                            flush_flag <= 1'b0;
                        end else begin
                            rd_beat <= rd_beat + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output beat assembly straight from the buffer; bytes past wr_ptr read as zero
    always_comb begin
        axis_out_tdata = '0;
        axis_out_tkeep = '0;
        for (int i = 0; i < 8; i++) begin
            rd_addr[i] = rd_base + PW'(i);
            if (state == SEND && rd_addr[i] < wr_ptr) begin
                axis_out_tdata[63-8*i -: 8] = mem[rd_addr[i]];
                axis_out_tkeep[7-i]         = 1'b1;
            end
        end
        axis_out_tvalid = (state == SEND);
        axis_out_tlast  = (state == SEND) && last_beat;
        pkt_done        = (state == SEND) && last_beat && axis_out_tready;
        err_len         = err_q;
    end
endmodule

// File: tb/tb_msg_pack.sv
// tb/tb_msg_pack.sv - scoreboard bench for msg_pack
module tb_msg_pack;
    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic        axis_in_tvalid = 1'b0;
    logic        axis_in_tready;
    logic [63:0] axis_in_tdata = '0;
    logic [7:0]  axis_in_tkeep = '0;
    logic        axis_in_tlast = 1'b0;
    logic        axis_out_tvalid;
    logic        axis_out_tready = 1'b1;
    logic [63:0] axis_out_tdata;
    logic [7:0]  axis_out_tkeep;
    logic        axis_out_tlast;
    logic        flush_req = 1'b0;
    logic        err_len;
    logic        pkt_done;

    always #5 clk = ~clk;

    msg_pack dut (
        .clk(clk), .areset_n(areset_n),
        .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
        .axis_in_tdata(axis_in_tdata), .axis_in_tkeep(axis_in_tkeep),
        .axis_in_tlast(axis_in_tlast),
        .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
        .axis_out_tdata(axis_out_tdata), .axis_out_tkeep(axis_out_tkeep),
        .axis_out_tlast(axis_out_tlast),
        .flush_req(flush_req), .err_len(err_len), .pkt_done(pkt_done)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t      sbq[$];
    logic [7:0] pb[$];
    int total = 0, bad = 0;
    int mcount = 0, err_exp = 0, err_seen = 0, done_exp = 0, done_seen = 0;
    int tv_seen = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_packet();
        logic [7:0] full[$];
        int nb;
        beat_t b;
        full.push_back(8'(mcount >> 8));
        full.push_back(8'(mcount));
        foreach (pb[j]) full.push_back(pb[j]);
        nb = full.size();
        for (int k = 0; k < (nb + 7) / 8; k++) begin
            b = '0;
            for (int i = 0; i < 8; i++) begin
                if (8 * k + i < nb) begin
                    b.d[63-8*i -: 8] = full[8*k+i];
                    b.k[7-i] = 1'b1;
                end
            end
            b.l = (8 * k + 8 >= nb);
            sbq.push_back(b);
        end
        done_exp++;
        pb.delete();
        mcount = 0;
    endtask

    task automatic model_msg(input int len, input logic [7:0] base);
        if (len < 8 || len > 32) begin
            err_exp++;
        end else begin
            pb.push_back(8'(len >> 8));
            pb.push_back(8'(len));
            for (int j = 0; j < len; j++) pb.push_back(base + 8'(j));
            mcount++;
            if (mcount == 16 || 2 + pb.size() + 2 + 32 > 1500) push_packet();
        end
    endtask

    task automatic send_msg(input int len, input logic [7:0] base);
        int nbt, n;
        nbt = (len + 7) / 8;
        for (int k = 0; k < nbt; k++) begin
            @(negedge clk);
            axis_in_tvalid = 1'b1;
            axis_in_tlast  = (k == nbt - 1);
            axis_in_tkeep  = (k == nbt - 1) ? 8'(len % 8) : 8'd0;
            for (int i = 0; i < 8; i++) axis_in_tdata[63-8*i -: 8] = base + 8'(8 * k + i);
            n = 0;
            while (!axis_in_tready && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 2000) chk("in_ready_timeout", 0, 1);
            @(posedge clk);
        end
        #1;
        axis_in_tvalid = 1'b0;
        axis_in_tlast  = 1'b0;
        model_msg(len, base);
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || axis_out_tvalid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard monitor: compare the presented beat every cycle, pop on handshake
    always @(negedge clk) begin
        if (err_len) err_seen++;
        if (pkt_done) done_seen++;
        if (axis_out_tvalid) tv_seen++;
        if (areset_n && axis_out_tvalid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                chk("beat_data", axis_out_tdata, sbq[0].d);
                chk("beat_keep", {56'd0, axis_out_tkeep}, {56'd0, sbq[0].k});
                chk("beat_last", {63'd0, axis_out_tlast}, {63'd0, sbq[0].l});
                if (axis_out_tready) begin
                    chk("pkt_done", {63'd0, pkt_done}, {63'd0, sbq[0].l});
                    chk("in_ready_in_send", {63'd0, axis_in_tready}, 64'd0);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        #2;
        chk("rst_tvalid", {63'd0, axis_out_tvalid}, 64'd0);
        chk("rst_tlast", {63'd0, axis_out_tlast}, 64'd0);
        chk("rst_tkeep", {56'd0, axis_out_tkeep}, 64'd0);
        chk("rst_tdata", axis_out_tdata, 64'd0);
        chk("rst_err", {63'd0, err_len}, 64'd0);
        chk("rst_done", {63'd0, pkt_done}, 64'd0);
        chk("rst_in_ready", {63'd0, axis_in_tready}, 64'd0);
        repeat (3) @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, axis_in_tready}, 64'd1);

        // 1: two messages then flush
        send_msg(8, 8'h01);
        send_msg(12, 8'h11);
        pulse_flush();
        push_packet();
        drain();

        // 2: sixteen messages close the packet without flush
        for (int m = 0; m < 16; m++) send_msg(8, 8'(8'h40 + 8'(m * 8)));
        chk("full_close_queued", sbq.size(), 21);
        drain();

        // 3: too short and too long messages dropped
        send_msg(4, 8'hA0);
        send_msg(40, 8'hB0);
        send_msg(8, 8'hC0);
        pulse_flush();
        push_packet();
        drain();
        chk("err_count", err_seen, 2);

        // 4: idle timeout closes the packet
        send_msg(8, 8'h21);
        push_packet();
        n = 0;
        while (!axis_out_tvalid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_close_window", {63'd0, (n >= 256 && n <= 260)}, 64'd1);
        drain();

        // 5: downstream stall plus flush during SEND
        send_msg(10, 8'h31);
        send_msg(9, 8'h51);
        pulse_flush();
        push_packet();
        n = 0;
        while (!axis_out_tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        axis_out_tready = 1'b0;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        repeat (4) @(negedge clk);
        axis_out_tready = 1'b1;
        drain();
        send_msg(8, 8'h61);
        tv_seen = 0;
        repeat (30) @(negedge clk);
        chk("flush_ignored", tv_seen, 0);
        pulse_flush();
        push_packet();
        drain();

        // 6: reset in the middle of SEND
        send_msg(8, 8'h71);
        send_msg(12, 8'h81);
        pulse_flush();
        push_packet();
        n = 0;
        while (sbq.size() > 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        areset_n = 1'b0;
        #1;
        chk("midrst_tvalid", {63'd0, axis_out_tvalid}, 64'd0);
        sbq.delete();
        done_exp--;
        pb.delete();
        mcount = 0;
        @(negedge clk);
        areset_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {63'd0, axis_in_tready}, 64'd1);
        send_msg(8, 8'h91);
        pulse_flush();
        push_packet();
        chk("fresh_pkt_beats", sbq.size(), 2);
        drain();

        chk("err_total", err_seen, err_exp);
        chk("pkt_done_total", done_seen, done_exp);
        chk("queue_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
